// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI master slice.
// Holds the FSM state encoding and default frame geometry.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH,
    DONE
  } state_e;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_CLK_DIV = 4;

endpackage

// File: rtl/spi_if.sv
// Handshake and serial lines between an SPI master and its user/slave.
// master modport is the controller side; slave modport is the peer side.
interface spi_if
  import spi_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] d;
  logic             sdi;
  logic             sck;
  logic             sdo;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] q;

  modport master (
    input  start, d, sdi,
    output sck, sdo, busy, done, q
  );

  modport slave (
    output start, d, sdi,
    input  sck, sdo, busy, done, q
  );

endinterface

// File: rtl/spi_sck_gen.sv
// Half-period divider for sck: ticks on the last clk of each half.
// Held at zero while disabled so every half-period starts clean.
module spi_sck_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_q;
  logic [DW-1:0] div_d;

  assign tick = en && (div_q == LAST);

  always_comb begin
    div_d = '0;
    if (en && !tick) begin
      div_d = div_q + DW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master: WIDTH-bit frames, MSB first, sck idle low.
// FSM and shift registers; half-period timing from spi_sck_gen.
module spi_master
  import spi_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input logic   clk,
  input logic   reset,
  spi_if.master bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] tx_q, tx_d;
  logic [WIDTH-1:0] rx_q, rx_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sck_q, sck_d;
  logic             sdo_q, sdo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             en;
  logic             tick;

  assign en = (state_q == LOW) || (state_q == HIGH);

  spi_sck_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sck (
    .clk  (clk),
    .reset(reset),
    .en   (en),
    .tick (tick)
  );

  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    sck_d   = sck_q;
    sdo_d   = sdo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          tx_d    = bus.d;
          sdo_d   = bus.d[WIDTH-1];
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = LOW;
        end
      end
      LOW: begin
        if (tick) begin
          sck_d   = 1'b1;
          rx_d    = {rx_q[WIDTH-2:0], bus.sdi};
          state_d = HIGH;
        end
      end
      HIGH: begin
        if (tick) begin
          sck_d = 1'b0;
          if (cnt_q == LAST) begin
            busy_d  = 1'b0;
            state_d = DONE;
          end else begin
            // sdo only ever moves on a falling sck edge
            tx_d    = tx_q << 1;
            sdo_d   = tx_q[WIDTH-2];
            cnt_d   = cnt_q + CW'(1);
            state_d = LOW;
          end
        end
      end
      DONE: begin
        done_d  = 1'b1;
        q_d     = rx_q;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      tx_q    <= '0;
      rx_q    <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      sck_q   <= 1'b0;
      sdo_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      sck_q   <= sck_d;
      sdo_q   <= sdo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.sck  = sck_q;
  assign bus.sdo  = sdo_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.q    = q_q;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: CLK_DIV=4 and CLK_DIV=1 instances with mode-0 slaves.
// Driver pushes expected frames; a monitor pops them on every done pulse.
module tb_spi_master;
  import spi_pkg::*;

  localparam int W = DEF_WIDTH;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] rx;
    int           cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  exp_t         sb_q [2][$];
  logic [W-1:0] ret_w [2][4];
  logic [1:0]   done_v, busy_v, sck_v, sdo_v;
  logic [W-1:0] q_v [2];
  logic [W-1:0] srx_v [2];
  int           rises_v [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_if #(.WIDTH(W)) bus [2] ();

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int CD = (g == 0) ? 4 : 1;
    logic [W-1:0] stx = '0;
    logic [W-1:0] srx = '0;
    int           nb = 0;
    int           rises = 0;
    logic [1:0]   idx = '0;

    spi_master #(.WIDTH(W), .CLK_DIV(CD)) u_dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus[g])
    );

    // mode-0 slave: sample on rise, advance on fall, reload after W bits
    assign bus[g].sdi = stx[W-1];
    always @(posedge reset or posedge bus[g].sck or negedge bus[g].sck) begin
      if (reset) begin
        nb  <= 0;
        idx <= '0;
        stx <= ret_w[g][0];
      end else if (bus[g].sck) begin
        srx   <= {srx[W-2:0], bus[g].sdo};
        nb    <= nb + 1;
        rises <= rises + 1;
      end else if (nb == W) begin
        nb  <= 0;
        idx <= idx + 2'd1;
        stx <= ret_w[g][idx + 2'd1];
      end else begin
        stx <= stx << 1;
      end
    end

    assign done_v[g]  = bus[g].done;
    assign busy_v[g]  = bus[g].busy;
    assign sck_v[g]   = bus[g].sck;
    assign sdo_v[g]   = bus[g].sdo;
    assign q_v[g]     = bus[g].q;
    assign srx_v[g]   = srx;
    assign rises_v[g] = rises;
  end

  function automatic void chk(input int i, input string nm,
                              input logic [W-1:0] act,
                              input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL u%0d.%s: got %h expected %h", i, nm, act, exp);
    end
  endfunction

  initial begin : monitor
    int   last_r [2];
    int   run [2];
    logic psck [2];
    logic psdo [2];
    logic pbusy [2];
    int   cd;
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      last_r[i] = 0;
      run[i]    = 0;
      psck[i]   = 1'b0;
      psdo[i]   = 1'b0;
      pbusy[i]  = 1'b0;
    end
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        cd = (i == 0) ? 4 : 1;
        if (reset) begin
          chk(i, "rst_sck", W'(sck_v[i]), '0);
          chk(i, "rst_sdo", W'(sdo_v[i]), '0);
          chk(i, "rst_busy", W'(busy_v[i]), '0);
          chk(i, "rst_done", W'(done_v[i]), '0);
          chk(i, "rst_q", q_v[i], '0);
          last_r[i] = rises_v[i];
          run[i]    = 0;
        end else begin
          if (done_v[i]) begin
            if (sb_q[i].size() == 0) begin
              n_cmp++;
              n_bad++;
              $display("FAIL u%0d.extra_done: got done at cycle %0d expected none",
                       i, cyc);
            end else begin
              e = sb_q[i].pop_front();
              chk(i, "done_cycle", W'(cyc), W'(e.cyc));
              chk(i, "q", q_v[i], e.q);
              chk(i, "slave_rx", srx_v[i], e.rx);
              chk(i, "rises", W'(rises_v[i] - last_r[i]), W'(W));
              chk(i, "busy_at_done", W'(busy_v[i]), '0);
            end
            last_r[i] = rises_v[i];
          end else if (sb_q[i].size() > 0 && cyc > sb_q[i][0].cyc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL u%0d.done_timeout: got no done by cycle %0d expected %0d",
                     i, cyc, sb_q[i][0].cyc);
            void'(sb_q[i].pop_front());
          end
          if (!busy_v[i]) chk(i, "sck_idle", W'(sck_v[i]), '0);
          if (sck_v[i] != psck[i]) begin
            chk(i, "half_period", W'(run[i]), W'(cd));
            if (sck_v[i]) chk(i, "sdo_at_rise", W'(sdo_v[i]), W'(psdo[i]));
            run[i] = 1;
          end else if (busy_v[i] && !pbusy[i]) begin
            run[i] = 1;
          end else begin
            run[i]++;
          end
        end
        psck[i]  = sck_v[i];
        psdo[i]  = sdo_v[i];
        pbusy[i] = busy_v[i];
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic push(input int i, input logic [W-1:0] q,
                      input logic [W-1:0] rx, input int c);
    exp_t e;
    e.q   = q;
    e.rx  = rx;
    e.cyc = c;
    sb_q[i].push_back(e);
  endtask

  task automatic rst_pulse(input int n);
    reset = 1'b1;
    tick(n);
    reset = 1'b0;
    tick(2);
  endtask

  initial begin : driver
    int t0;
    bus[0].start = 1'b0;
    bus[1].start = 1'b0;
    bus[0].d     = '0;
    bus[1].d     = '0;
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 4; k++) ret_w[i][k] = '0;
    ret_w[0][0] = 32'h0000_03FF;
    ret_w[1][0] = 32'h8000_0001;
    #1 reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(2);

    // basic frame on both divider settings
    t0 = cyc + 1;
    bus[0].start = 1'b1;
    bus[0].d     = 32'hA5A5_0F0F;
    bus[1].start = 1'b1;
    bus[1].d     = 32'hFFFF_FFFF;
    push(0, 32'h0000_03FF, 32'hA5A5_0F0F, t0 + 257);
    push(1, 32'h8000_0001, 32'hFFFF_FFFF, t0 + 65);
    tick(1);
    bus[0].start = 1'b0;
    bus[1].start = 1'b0;
    bus[0].d     = '0;
    bus[1].d     = '0;
    wait_cyc(t0 + 280);

    // start pulses mid-frame and during DONE are ignored
    ret_w[0][0] = 32'hCAFE_F00D;
    rst_pulse(2);
    t0 = cyc + 1;
    bus[0].start = 1'b1;
    bus[0].d     = 32'h1234_5678;
    push(0, 32'hCAFE_F00D, 32'h1234_5678, t0 + 257);
    tick(1);
    bus[0].start = 1'b0;
    bus[0].d     = '0;
    wait_cyc(t0 + 20);
    bus[0].start = 1'b1;
    tick(1);
    bus[0].start = 1'b0;
    wait_cyc(t0 + 100);
    bus[0].start = 1'b1;
    bus[0].d     = 32'hFFFF_0000;
    tick(3);
    bus[0].start = 1'b0;
    bus[0].d     = '0;
    wait_cyc(t0 + 249);
    bus[0].start = 1'b1;
    tick(8);
    bus[0].start = 1'b0;
    wait_cyc(t0 + 300);

    // start held high: three back-to-back frames
    ret_w[0][0] = 32'd1;
    ret_w[0][1] = 32'd2;
    ret_w[0][2] = 32'd3;
    ret_w[0][3] = '0;
    rst_pulse(2);
    t0 = cyc + 1;
    bus[0].start = 1'b1;
    bus[0].d     = 32'h0F0F_F0F0;
    push(0, 32'd1, 32'h0F0F_F0F0, t0 + 257);
    push(0, 32'd2, 32'h0F0F_F0F0, t0 + 515);
    push(0, 32'd3, 32'h0F0F_F0F0, t0 + 773);
    wait_cyc(t0 + 600);
    bus[0].start = 1'b0;
    wait_cyc(t0 + 790);

    // reset during bit 10 aborts the frame, then a fresh frame
    ret_w[0][0] = 32'h0000_0AAA;
    t0 = cyc + 1;
    bus[0].start = 1'b1;
    bus[0].d     = 32'hDEAD_BEEF;
    tick(1);
    bus[0].start = 1'b0;
    wait_cyc(t0 + 84);
    rst_pulse(2);
    t0 = cyc + 1;
    bus[0].start = 1'b1;
    bus[0].d     = 32'h0000_0155;
    push(0, 32'h0000_0AAA, 32'h0000_0155, t0 + 257);
    tick(1);
    bus[0].start = 1'b0;
    wait_cyc(t0 + 280);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter WIDTH, default 32, frame length in bits; SHALL be >= 2.
REQ-002 Parameter CLK_DIV, default 4, sck half-period in clk cycles; SHALL be >= 1.
REQ-003 clk  input  1  single system clock; all logic SHALL be clocked on posedge clk only.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request a transfer; sampled only in IDLE.
REQ-006 d  input  WIDTH  word to transmit, MSB first; latched on accepted start.
REQ-007 sdi  input  1  serial data from slave.
REQ-008 sck  output  1  serial clock, idle low (mode 0).
REQ-009 sdo  output  1  serial data to slave.
REQ-010 busy  output  1  high while a frame is in progress.
REQ-011 done  output  1  one-cycle pulse at end of frame.
REQ-012 q  output  WIDTH  word received in the last completed frame.

Function
REQ-013 FSM states: IDLE, LOW (sck low half-period), HIGH (sck high half-period), DONE.
REQ-014 IDLE: start=1 SHALL latch d into tx shift register, drive sdo=d[WIDTH-1], clear bit counter and divider, enter LOW; busy=1 from the next cycle.
REQ-015 Divider SHALL count 0..CLK_DIV-1 in LOW and HIGH; terminal count ends the half-period and reloads 0.
REQ-016 LOW terminal count: sck SHALL rise at that clk edge; sdi SHALL be sampled at the same edge into rx shift register LSB (rx <= {rx[WIDTH-2:0], sdi}); enter HIGH.
REQ-017 HIGH terminal count: sck SHALL fall; if bit counter = WIDTH-1 enter DONE, else shift tx left, sdo <= next bit, bit counter +1, enter LOW.
REQ-018 sdo SHALL change only at sck falling edges or on start acceptance, never at a rising edge.
REQ-019 Frame SHALL contain exactly WIDTH sck rising edges; sck high time and low time each exactly CLK_DIV clk cycles.
REQ-020 DONE: done=1 and q <= rx for exactly one cycle, busy=0, sck=0; next state IDLE.
REQ-021 Start-to-done latency SHALL be 2*WIDTH*CLK_DIV + 1 clk cycles (start edge to done-high edge).
REQ-022 start while busy or in DONE SHALL be ignored; no queuing; d changes while busy SHALL have no effect.
REQ-023 Back-to-back: start held high SHALL begin the next frame on the first cycle after DONE (IDLE visited for one cycle).
REQ-024 q SHALL hold its value until the next DONE; it SHALL NOT show partial frames.
REQ-025 Bit counter width SHALL be $clog2(WIDTH); no wrap within a frame.

Reset
REQ-026 reset=1 at any time, including mid-frame, SHALL on that edge force IDLE, sck=0, sdo=0, busy=0, done=0, q=0, counters and shift registers 0.
REQ-027 The remote slave's bit counter is reset by the same system reset; reset SHALL be asserted to both ends together, and the aborted frame is discarded.
REQ-028 reset SHALL have priority over start in the same cycle.

Structure
REQ-029 Shared package spi_pkg SHALL hold the state enum (IDLE, LOW, HIGH, DONE) and the default WIDTH/CLK_DIV constants.
REQ-030 One sub-module, spi_sck_gen (half-period divider emitting a terminal-count tick, enabled in LOW/HIGH), SHALL be used; the FSM and shift registers stay in spi_master.

Verification (bench models a mode-0 WIDTH-bit slave: samples sdo on sck rise, updates sdi on sck fall, preloads first bit)
REQ-031 CLK_DIV=4, d=32'hA5A5_0F0F, slave returns 32'h0000_03FF -> slave receives A5A5_0F0F; done pulses once 257 cycles after start; q=32'h0000_03FF; exactly 32 sck rises.
REQ-032 CLK_DIV=1, d=32'hFFFF_FFFF, slave returns 32'h8000_0001 -> sck = clk/2; q=32'h8000_0001; latency 65 cycles.
REQ-033 start pulsed repeatedly mid-frame with d=32'h1234_5678 then d=0 -> only one frame; slave receives 1234_5678; single done.
REQ-034 start held high for three frames, slave returns 1,2,3 -> three done pulses spaced 258 cycles (CLK_DIV=4); q sequence 1,2,3.
REQ-035 reset asserted at bit 10 of a frame -> next edge sck=0, sdo=0, busy=0, q=0, no done; a following fresh frame with d=32'h0000_0155 completes correctly.
REQ-036 Assertions throughout: sdo stable across every sck rise; done never high with busy high; sck=0 whenever busy=0.
